// File: rtl/ethgen_frame_scheduler.sv
// ethgen_frame_scheduler: queues frame descriptors and launches them into the traffic generator
// with a start/done handshake, per-frame inter-frame gap, start timeout and frame/byte statistics.
module ethgen_frame_scheduler #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        desc_valid,
    output logic        desc_ready,
    input  logic [15:0] desc_len,
    input  logic [15:0] desc_ipg,
    input  logic [3:0]  desc_flags,
    output logic        gen_start,
    output logic [15:0] gen_len,
    output logic [15:0] gen_ipg_len,
    output logic [3:0]  gen_flags,
    input  logic        gen_done,
    output logic        busy,
    output logic [31:0] frame_cnt,
    output logic [31:0] byte_cnt,
    output logic        timeout_err,
    input  logic        clr_stats
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, START, BUSY, GAP} state_t;
    state_t        state;
    logic [35:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [31:0]   wait_cnt;
    logic [15:0]   gap_cnt;
    logic          push, pop, empty;
    assign empty      = count == '0;
    assign desc_ready = count != (AW+1)'(DEPTH);
    assign push       = desc_valid && desc_ready;
    assign pop        = state == IDLE && enable && !empty && gen_done;
    assign busy       = state != IDLE || !empty;
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {desc_len, desc_ipg, desc_flags};
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            gen_start   <= 1'b0;
            gen_len     <= '0;
            gen_ipg_len <= '0;
            gen_flags   <= '0;
            frame_cnt   <= '0;
            byte_cnt    <= '0;
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
            gap_cnt     <= '0;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    {gen_len, gen_ipg_len, gen_flags} <= mem[rd_ptr];
                    gen_start <= 1'b1;
                    wait_cnt  <= '0;
                    state     <= START;
                end
                START: if (!gen_done) begin
                    gen_start <= 1'b0;
                    state     <= BUSY;
                end else if (wait_cnt == 32'(TIMEOUT - 1)) begin
                    gen_start   <= 1'b0;
                    timeout_err <= 1'b1;
                    state       <= IDLE;
                end else begin
                    wait_cnt <= wait_cnt + 32'd1;
                end
                BUSY: if (gen_done) begin
                    frame_cnt <= frame_cnt + 32'd1;
                    byte_cnt  <= byte_cnt + {16'h0, gen_len};
                    gap_cnt   <= gen_ipg_len;
                    state     <= gen_ipg_len == '0 ? IDLE : GAP;
                end
                GAP: begin
                    gap_cnt <= gap_cnt - 16'd1;
                    if (gap_cnt == 16'd1) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // a clear wins over a completion or timeout landing in the same cycle
            if (clr_stats) begin
                frame_cnt   <= '0;
                byte_cnt    <= '0;
                timeout_err <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ethgen_frame_scheduler.sv
// tb_ethgen_frame_scheduler: directed stimulus, a generator model, and a time-based
// transaction model of the scheduler compared against the DUT every cycle.
module tb_ethgen_frame_scheduler;
    localparam int DEPTH = 4;
    localparam int TO    = 20;
    localparam int DROP  = 2;
    localparam int RUN   = 40;

    logic        clk = 0, reset_n = 0, enable = 0, desc_valid = 0, gen_done = 1, clr_stats = 0;
    logic [15:0] desc_len = 0, desc_ipg = 0;
    logic [3:0]  desc_flags = 0;
    logic        desc_ready, gen_start, busy, timeout_err;
    logic [15:0] gen_len, gen_ipg_len;
    logic [3:0]  gen_flags;
    logic [31:0] frame_cnt, byte_cnt;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    ethgen_frame_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .desc_valid(desc_valid),
        .desc_ready(desc_ready), .desc_len(desc_len), .desc_ipg(desc_ipg),
        .desc_flags(desc_flags), .gen_start(gen_start), .gen_len(gen_len),
        .gen_ipg_len(gen_ipg_len), .gen_flags(gen_flags), .gen_done(gen_done),
        .busy(busy), .frame_cnt(frame_cnt), .byte_cnt(byte_cnt),
        .timeout_err(timeout_err), .clr_stats(clr_stats)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, want, want);
        end
    endtask

    // generator: drops done DROP cycles after seeing start, raises it RUN cycles later
    logic stuck = 0, clr_on_done = 0;
    int   gcnt = 0;
    always @(posedge clk) begin
        #1;
        clr_stats = 1'b0;
        if (!reset_n) begin
            gen_done = 1'b1;
            gcnt = 0;
        end else if (gcnt != 0) begin
            gcnt++;
            if (gcnt == DROP + 1) gen_done = 1'b0;
            else if (gcnt == DROP + 1 + RUN) begin
                gen_done  = 1'b1;
                gcnt      = 0;
                clr_stats = clr_on_done;
            end
        end else if (gen_start && !stuck) gcnt = 1;
    end

    // model: phase 0 idle, 1 awaiting ack, 2 generator running; idle_at is first cycle free to launch
    typedef struct packed {logic [15:0] len; logic [15:0] ipg; logic [3:0] flags;} desc_t;
    desc_t       q[$];
    desc_t       cur = '0;
    int          phase = 0, cyc = 0, idle_at = 0, launch_c = 0;
    logic        exp_start = 0, exp_to = 0;
    logic [31:0] exp_frames = 0, exp_bytes = 0;
    always @(posedge clk) begin : model_p
        bit acc;
        if (!reset_n) begin
            q.delete();
            cur = '0; phase = 0; idle_at = 0; exp_start = 0; exp_to = 0;
            exp_frames = 0; exp_bytes = 0;
        end else begin
            acc = desc_valid && q.size() < DEPTH;
            if (phase == 0 && cyc >= idle_at && enable && q.size() > 0 && gen_done) begin
                cur = q.pop_front();
                phase = 1; launch_c = cyc; exp_start = 1;
            end else if (phase == 1 && !gen_done) begin
                phase = 2; exp_start = 0;
            end else if (phase == 1 && cyc == launch_c + TO) begin
                phase = 0; exp_start = 0; exp_to = 1; idle_at = cyc + 1;
            end else if (phase == 2 && gen_done) begin
                phase = 0;
                exp_frames = exp_frames + 32'd1;
                exp_bytes  = exp_bytes + 32'(cur.len);
                idle_at    = cyc + 1 + int'(cur.ipg);
            end
            if (acc) q.push_back(desc_t'({desc_len, desc_ipg, desc_flags}));
            if (clr_stats) begin exp_frames = 0; exp_bytes = 0; exp_to = 0; end
        end
        cyc++;
    end

    always @(negedge clk) begin
        chk("gen_start", 32'(gen_start), 32'(exp_start));
        chk("gen_len", 32'(gen_len), 32'(cur.len));
        chk("gen_ipg_len", 32'(gen_ipg_len), 32'(cur.ipg));
        chk("gen_flags", 32'(gen_flags), 32'(cur.flags));
        chk("desc_ready", 32'(desc_ready), 32'(q.size() < DEPTH));
        chk("busy", 32'(busy), 32'(phase != 0 || cyc < idle_at || q.size() != 0));
        chk("frame_cnt", frame_cnt, exp_frames);
        chk("byte_cnt", byte_cnt, exp_bytes);
        chk("timeout_err", 32'(timeout_err), 32'(exp_to));
    end

    // start-pulse monitor
    int   n_starts = 0, hi_len = 0, last_hi = 0;
    int   rise_c[$];
    logic prev_start = 0;
    always @(negedge clk) begin
        if (gen_start && !prev_start) begin n_starts++; rise_c.push_back(cyc); hi_len = 0; end
        if (gen_start) hi_len++;
        else if (prev_start) last_hi = hi_len;
        prev_start = gen_start;
    end

    task automatic push(input logic [15:0] l, input logic [15:0] g, input logic [3:0] f);
        @(posedge clk); #1;
        desc_valid = 1; desc_len = l; desc_ipg = g; desc_flags = f;
        @(posedge clk); #1;
        desc_valid = 0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin @(negedge clk); n++; end while ((busy || !gen_done) && n < 2000);
        chk({name, "_idle_wait"}, 32'(n < 2000), 32'd1);
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int base, n;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(desc_ready), 32'd1);
        chk("rst_start", 32'(gen_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_len", 32'(gen_len), 32'd0);
        #1 reset_n = 1;

        enable = 1;
        push(16'd64, 16'd0, 4'b0001);
        push(16'd100, 16'd12, 4'b1010);
        push(16'd1500, 16'd0, 4'b0100);
        wait_idle("t1");
        chk("t1_frames", frame_cnt, 32'd3);
        chk("t1_bytes", byte_cnt, 32'd1664);
        chk("t1_starts", 32'(n_starts), 32'd3);
        chk("t1_spacing_ipg0", 32'(rise_c[1] - rise_c[0]), 32'd44);
        chk("t1_spacing_ipg12", 32'(rise_c[2] - rise_c[1]), 32'd56);

        enable = 0;
        for (int i = 0; i < DEPTH; i++) push(16'(10 + i), 16'(i), 4'(i + 1));
        @(negedge clk);
        chk("t2_full", 32'(desc_ready), 32'd0);
        push(16'd99, 16'd0, 4'b1111);
        @(negedge clk);
        chk("t2_still_full", 32'(desc_ready), 32'd0);
        base = n_starts;
        enable = 1;
        wait_idle("t2");
        chk("t2_starts", 32'(n_starts - base), 32'(DEPTH));
        chk("t2_frames", frame_cnt, 32'd7);
        chk("t2_bytes", byte_cnt, 32'd1710);

        stuck = 1;
        push(16'd200, 16'd0, 4'b0011);
        n = 0;
        do begin @(negedge clk); n++; end while (!timeout_err && n < 200);
        chk("t3_timeout_err", 32'(timeout_err), 32'd1);
        @(negedge clk);
        stuck = 0;
        chk("t3_start_width", 32'(last_hi), 32'(TO));
        chk("t3_frames", frame_cnt, 32'd7);
        push(16'd300, 16'd5, 4'b0000);
        wait_idle("t3");
        chk("t3_frames_after", frame_cnt, 32'd8);
        chk("t3_bytes", byte_cnt, 32'd2010);

        push(16'd400, 16'd3, 4'b1000);
        n = 0;
        do begin @(negedge clk); n++; end while (gen_done && n < 100);
        chk("t4_gen_running", 32'(gen_done), 32'd0);
        @(negedge clk);
        enable = 0;
        base = n_starts;
        push(16'd500, 16'd0, 4'b0000);
        repeat (80) @(negedge clk);
        chk("t4_no_start", 32'(n_starts), 32'(base));
        chk("t4_frames", frame_cnt, 32'd9);
        chk("t4_busy_queued", 32'(busy), 32'd1);
        enable = 1;
        wait_idle("t4");
        chk("t4_frames_after", frame_cnt, 32'd10);
        chk("t4_bytes", byte_cnt, 32'd2910);

        clr_on_done = 1;
        push(16'd600, 16'd0, 4'b0000);
        wait_idle("t5");
        clr_on_done = 0;
        chk("t5_frames", frame_cnt, 32'd0);
        chk("t5_bytes", byte_cnt, 32'd0);
        chk("t5_timeout_err", 32'(timeout_err), 32'd0);

        stuck = 1;
        push(16'd700, 16'd0, 4'b0001);
        push(16'd800, 16'd0, 4'b0010);
        n = 0;
        while (!gen_start && n < 50) begin @(negedge clk); n++; end
        chk("t6_in_start", 32'(gen_start), 32'd1);
        @(negedge clk);
        #1 reset_n = 0;
        #1;
        chk("t6_rst_start", 32'(gen_start), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_ready", 32'(desc_ready), 32'd1);
        stuck = 0;
        repeat (2) @(negedge clk);
        #1 reset_n = 1;
        push(16'd50, 16'd0, 4'b0101);
        wait_idle("t6");
        chk("t6_frames", frame_cnt, 32'd1);
        chk("t6_bytes", byte_cnt, 32'd50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ethgen_frame_scheduler.md
Name: ethgen_frame_scheduler

Overview:
- Sequences a queue of frame descriptors into the Ethernet traffic generator model used by the TSE MAC testbenches.
- Buffers descriptors in a small FIFO and drives the generator's start, len, ipg_len and error/feature flags.
- Runs a start/done handshake with the generator, enforces per-frame inter-frame gaps, and keeps frame and byte statistics.
- Simulation/testbench infrastructure; sits between the test sequence and the generator wrapper.

Parameters:
DEPTH, 4, descriptor FIFO depth (power of 2, >=2)
TIMEOUT, 1024, cycles to wait for gen_done to fall after start before abandoning a frame

Ports:
clk  in  1  word clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  1 = pop and launch queued descriptors; 0 = finish current frame, launch no new one
desc_valid  in  1  descriptor push request
desc_ready  out  1  FIFO not full
desc_len  in  16  payload length
desc_ipg  in  16  extra idle cycles after the frame completes
desc_flags  in  4  {vlan_en, pad_en, crc_err, payload_err}
gen_start  out  1  start request to the generator
gen_len  out  16  latched length
gen_ipg_len  out  16  latched IPG
gen_flags  out  4  latched flags
gen_done  in  1  generator idle (1) / running (0)
busy  out  1  state != IDLE or FIFO not empty
frame_cnt  out  32  completed frames
byte_cnt  out  32  sum of len over completed frames
timeout_err  out  1  sticky: a start was never acknowledged
clr_stats  in  1  synchronous clear of frame_cnt, byte_cnt and timeout_err

Behaviour:
- Reset (async, reset_n=0):
  - FIFO empty; desc_ready=1.
  - gen_start, gen_len, gen_ipg_len, gen_flags = 0.
  - Counters = 0; timeout_err = 0; state = IDLE; busy = 0.
- FIFO:
  - Push when desc_valid & desc_ready. desc_ready = !full (combinational from the occupancy count).
  - No bypass: a descriptor pushed into an empty FIFO is poppable the next cycle.
  - Push and pop in the same cycle are both allowed; occupancy is unchanged.
  - Pointers wrap modulo DEPTH.
- States: IDLE, START, BUSY, GAP.
- IDLE:
  - If enable & !empty & gen_done: pop the head and register len/ipg/flags onto the gen_* outputs.
  - Set gen_start=1 and go to START. First gen_start is 1 cycle after the pop decision.
- START:
  - gen_start held 1; gen_* outputs stable.
  - If gen_done==0: gen_start<=0, go to BUSY.
  - Else increment the wait counter. On reaching TIMEOUT-1: gen_start<=0, timeout_err<=1, frame dropped (not counted), go to IDLE.
- BUSY:
  - gen_* outputs held stable.
  - On gen_done==1: frame_cnt+=1; byte_cnt+=len (zero-extended).
  - If ipg==0, go to IDLE; else load the gap counter with ipg and go to GAP.
- GAP:
  - Decrement each cycle; go to IDLE when the counter reaches 1. Gives exactly ipg idle cycles before IDLE.
  - The next start rises no earlier than ipg+2 cycles after gen_done rose.
- Counters wrap modulo 2^32.
- clr_stats has priority over a same-cycle increment.
- enable deassert mid-frame: the current frame completes, including GAP. enable is sampled only in IDLE.
- gen_* data outputs retain their last values in IDLE; only gen_start returns to 0.
- reset_n asserted mid-frame: immediate return to reset values; queued descriptors are lost.

Test Plan:
- Push 3 descriptors (len 64/100/1500, ipg 0/12/0) with enable=1 and a generator model that drops done 2 cycles after start and raises it 40 cycles later -> 3 starts; frame_cnt=3; byte_cnt=1664; the second-to-third start spacing includes exactly 12 idle GAP cycles.
- Push DEPTH+1 descriptors with enable=0 -> desc_ready=0 after DEPTH pushes and the extra push is ignored; set enable=1 -> DEPTH frames launched, in order.
- gen_done held at 1 -> gen_start high for TIMEOUT cycles, then 0; timeout_err=1; frame_cnt unchanged; the next descriptor launches.
- Drop enable while in BUSY -> the frame completes and is counted; no further start until enable returns.
- Assert clr_stats in the same cycle as a frame completion -> frame_cnt=0, byte_cnt=0.
- Assert reset_n=0 while in START -> gen_start=0 immediately, busy=0, desc_ready=1.
